// File: rtl/bus_demux3_pkg.sv
// Shared state encoding, slave indices and select helper for the 3-way bus demux.
package bus_demux3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_MEM  = 2'd0;
  localparam logic [1:0] SEL_MMIO = 2'd1;
  localparam logic [1:0] SEL_DBG  = 2'd2;

  // Index 3 never decodes, so it maps to no slave at all.
  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    return 3'b001 << sel;
  endfunction

endpackage

// File: rtl/bus_demux3_decode.sv
// Address region decode: masked address against the MMIO and debug bases, memory otherwise.
// Latency: combinational. Backpressure: none.
module addr_decode3 #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] S1_BASE     = WIDTH'(32'hFFFF_0000),
  parameter logic [WIDTH-1:0] S2_BASE     = WIDTH'(32'hFFFE_0000),
  parameter logic [WIDTH-1:0] REGION_MASK = WIDTH'(32'hFFFF_0000)
) (
  input  logic [WIDTH-1:0] addr,
  output logic [1:0]       sel
);
  import bus_demux3_pkg::*;

  logic [WIDTH-1:0] region;

  assign region = addr & REGION_MASK;

  // MMIO wins if both bases are ever configured to the same region.
  always_comb begin
    sel = SEL_MEM;
    if (region == S1_BASE)
      sel = SEL_MMIO;
    else if (region == S2_BASE)
      sel = SEL_DBG;
  end

endmodule

// File: rtl/mux3.sv
// Generic three-input data mux.
// Latency: combinational. Backpressure: none.
module mux3 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/bus_demux3.sv
// Single-outstanding request demux from one master to three slaves with response timeout.
// Latency: 3 cycles accept-to-m_rvalid minimum, +1 per stalled ISSUE/WAIT cycle.
// Backpressure: m_ready low while a request is in flight; ISSUE waits on s_ready forever.
module bus_demux3 #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] S1_BASE     = WIDTH'(32'hFFFF_0000),
  parameter logic [WIDTH-1:0] S2_BASE     = WIDTH'(32'hFFFE_0000),
  parameter logic [WIDTH-1:0] REGION_MASK = WIDTH'(32'hFFFF_0000),
  parameter int               TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [WIDTH-1:0] m_addr,
  input  logic [WIDTH-1:0] m_wdata,
  input  logic             m_we,
  output logic             m_rvalid,
  output logic [WIDTH-1:0] m_rdata,
  output logic             m_err,
  output logic [2:0]       s_valid,
  input  logic [2:0]       s_ready,
  output logic [WIDTH-1:0] s_addr,
  output logic [WIDTH-1:0] s_wdata,
  output logic             s_we,
  input  logic [2:0]       s_rvalid,
  input  logic [WIDTH-1:0] s_rdata0,
  input  logic [WIDTH-1:0] s_rdata1,
  input  logic [WIDTH-1:0] s_rdata2
);
  import bus_demux3_pkg::*;

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t           state;
  logic [1:0]       dec_sel;
  logic [1:0]       sel_q;
  logic [2:0]       sel_oh;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             we_q;
  logic [WIDTH-1:0] rsp_dat;
  logic [CW-1:0]    cnt;
  logic             req_ack;
  logic             rsp_hit;

  addr_decode3 #(
    .WIDTH       (WIDTH),
    .S1_BASE     (S1_BASE),
    .S2_BASE     (S2_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decode (
    .addr (m_addr),
    .sel  (dec_sel)
  );

  mux3 #(
    .WIDTH (WIDTH)
  ) u_rsp_mux (
    .sel (sel_q),
    .d0  (s_rdata0),
    .d1  (s_rdata1),
    .d2  (s_rdata2),
    .y   (rsp_dat)
  );

  // Handshakes only count on the latched slave; other slaves' strobes are ignored.
  assign sel_oh  = sel_onehot(sel_q);
  assign req_ack = |(s_ready & sel_oh);
  assign rsp_hit = |(s_rvalid & sel_oh);

  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_we    = we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      m_ready  <= 1'b1;
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
      m_err    <= 1'b0;
      s_valid  <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      sel_q    <= SEL_MEM;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_valid) begin
            addr_q  <= m_addr;
            wdata_q <= m_wdata;
            we_q    <= m_we;
            sel_q   <= dec_sel;
            s_valid <= sel_onehot(dec_sel);
            m_ready <= 1'b0;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (req_ack) begin
            s_valid <= 3'b000;
            cnt     <= '0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          // A response landing on the final count still beats the timeout.
          if (rsp_hit) begin
            m_rdata  <= rsp_dat;
            m_err    <= 1'b0;
            m_rvalid <= 1'b1;
            state    <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            m_rdata  <= '0;
            m_err    <= 1'b1;
            m_rvalid <= 1'b1;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          m_rvalid <= 1'b0;
          m_ready  <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          m_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_demux3.md
BUS_DEMUX3 -- requirements
Module: bus_demux3

Interface
REQ-001 Parameter WIDTH, default 32: address and data width.
REQ-002 Parameter S1_BASE, default 32'hFFFF_0000: base address of slave 1 (MMIO).
REQ-003 Parameter S2_BASE, default 32'hFFFE_0000: base address of slave 2 (debug).
REQ-004 Parameter REGION_MASK, default 32'hFFFF_0000: mask applied to the address before comparing it with S1_BASE and S2_BASE.
REQ-005 Parameter TIMEOUT, default 255: maximum number of cycles spent waiting for a slave response before an error is returned.
REQ-006 clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 m_valid  in  1  master request valid.
REQ-009 m_ready  out  1  request accepted by the block.
REQ-010 m_addr, m_wdata  in  WIDTH each  request address and write data.
REQ-011 m_we  in  1  write enable; 1 = write, 0 = read.
REQ-012 m_rvalid  out  1  one-cycle response strobe to the master.
REQ-013 m_rdata  out  WIDTH  response read data.
REQ-014 m_err  out  1  response error flag, qualified by m_rvalid.
REQ-015 s_valid[2:0]  out  3  per-slave request valid.
REQ-016 s_ready[2:0]  in  3  per-slave request ready.
REQ-017 s_addr, s_wdata  out  WIDTH each  request address and write data, shared by all slaves.
REQ-018 s_we  out  1  write enable, shared by all slaves.
REQ-019 s_rvalid[2:0]  in  3  per-slave response valid.
REQ-020 s_rdata0, s_rdata1, s_rdata2  in  WIDTH each  per-slave response data.

Function
REQ-021 Slave select:
- 2'd1 if (m_addr & REGION_MASK) == S1_BASE;
- otherwise 2'd2 if (m_addr & REGION_MASK) == S2_BASE;
- otherwise 2'd0.
REQ-022 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-023 IDLE:
- m_ready=1.
- On m_valid, latch addr, wdata, we and the select, then go to ISSUE.
REQ-024 ISSUE:
- s_valid[sel]=1 and all other s_valid bits are 0.
- s_addr, s_wdata and s_we are driven from the latched copies.
- On s_ready[sel], go to WAIT.
REQ-025 WAIT:
- Counter increments each cycle.
- On s_rvalid[sel], capture the matching s_rdata and go to RESP with err=0.
- When the counter reaches TIMEOUT, go to RESP with rdata=0 and err=1.
REQ-026 RESP: m_rvalid=1 for exactly one cycle, m_rdata and m_err are held from the capture, then the FSM returns to IDLE.
REQ-027 m_ready=0 in ISSUE, WAIT and RESP; at most one request is outstanding.
REQ-028 Minimum latency, from m_valid accepted to m_rvalid:
- 3 cycles when s_ready and s_rvalid are asserted immediately;
- one extra cycle per stalled ISSUE or WAIT cycle.
REQ-029 s_rvalid from any slave other than the latched select is ignored in every state.
REQ-030 s_rvalid asserted in the same cycle as the ISSUE handshake is ignored; responses are sampled only in WAIT.
REQ-031 The ISSUE state has no timeout; a slave that never asserts s_ready stalls the block indefinitely.
REQ-032 When the counter reaches TIMEOUT in the same cycle that s_rvalid[sel] arrives, the valid response wins (err=0).
REQ-033 The timeout counter is cleared on entry to WAIT and is $clog2(TIMEOUT+1) bits wide.

Reset
REQ-034 Reset takes priority over all other inputs and returns the FSM to IDLE.
REQ-035 Output values after reset:
- m_ready=1;
- m_rvalid=0, m_err=0, m_rdata=0;
- s_valid=3'b000;
- latched addr, wdata and we =0;
- counter=0.
REQ-036 Reset asserted in ISSUE or WAIT abandons the transaction; no m_rvalid is generated for it.

Structure
REQ-037 A shared package holds:
- the state encoding;
- slave-index constants SEL_MEM=2'd0, SEL_MMIO=2'd1, SEL_DBG=2'd2.
REQ-038 Address decode is a separate combinational sub-module, addr_decode3, with inputs addr and outputs sel[1:0].
REQ-039 Response data selection uses the existing three-input mux, sel-driven, as an instance.

Verification
REQ-040 Read to 32'h0000_1000 with slave 0 ready and responding with 32'hDEAD_BEEF on the first WAIT cycle: s_valid=3'b001, m_rvalid on cycle 3, m_rdata=32'hDEAD_BEEF, m_err=0.
REQ-041 Write to 32'hFFFF_0004 with slave 1 holding s_ready low for 2 cycles: s_valid=3'b010 for 3 cycles, s_we=1, m_rvalid on cycle 5.
REQ-042 Read to 32'hFFFE_0000 with slave 2 never responding and TIMEOUT=4: m_rvalid with m_err=1 and m_rdata=0 exactly 4 cycles after entering WAIT.
REQ-043 Read to slave 0 while slave 1 pulses s_rvalid with 32'h1234 during WAIT: the pulse is ignored and m_rdata equals slave 0's later data.
REQ-044 With TIMEOUT=4, s_rvalid[sel] arrives on the same cycle the counter reaches 4: m_err=0 and the data is captured.
REQ-045 Reset asserted in WAIT: the next cycle has m_ready=1 and s_valid=0, and no m_rvalid pulse ever appears for the abandoned request.
